// File: rtl/cpu_regs_mp_pkg.sv
// cpu_regs_mp_pkg: shared widths, write-back task record and clear FSM states
package cpu_regs_mp_pkg;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int REG_DATA_WIDTH = 16;
  typedef struct packed {
    logic                      wr_en;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [REG_DATA_WIDTH-1:0] wr_data;
  } wb_task_t;
  typedef enum logic [1:0] {RC_IDLE, RC_CLEAR, RC_DONE} regs_clr_state_t;
endpackage

// File: rtl/cpu_regs_mp_if.sv
// cpu_regs_mp_if: decode/write-back side bundle of the multi-port register file
interface cpu_regs_mp_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
);
  import cpu_regs_mp_pkg::*;
  wb_task_t [WR_PORTS-1:0]             task_i;
  logic     [RD_PORTS-1:0][ADDR_W-1:0] rd_addr_i;
  logic     [RD_PORTS-1:0][DATA_W-1:0] rd_data_o;
  logic     [RD_PORTS-1:0]             rd_busy_o;
  logic                                claim_en_i;
  logic     [ADDR_W-1:0]               claim_addr_i;
  logic                                clr_req_i;
  logic                                clr_busy_o;
  modport master (
    output task_i, rd_addr_i, claim_en_i, claim_addr_i, clr_req_i,
    input  rd_data_o, rd_busy_o, clr_busy_o
  );
  modport slave (
    input  task_i, rd_addr_i, claim_en_i, claim_addr_i, clr_req_i,
    output rd_data_o, rd_busy_o, clr_busy_o
  );
endinterface

// File: rtl/cpu_regs_mp_scoreboard.sv
// cpu_regs_mp_scoreboard: per-register busy bits with claim/write/clear priority and per-port lookup
module cpu_regs_mp_scoreboard #(
  parameter int ADDR_W   = 3,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WR_PORTS-1:0]              wr_en,
  input  logic [WR_PORTS-1:0][ADDR_W-1:0]  wr_addr,
  input  logic                             claim_en,
  input  logic [ADDR_W-1:0]                claim_addr,
  input  logic                             clr_en,
  input  logic [ADDR_W-1:0]                clr_addr,
  input  logic                             byp_en,
  input  logic [RD_PORTS-1:0][ADDR_W-1:0]  rd_addr,
  output logic [RD_PORTS-1:0]              rd_busy
);
  localparam int REGS_CNT = 2**ADDR_W;
  logic [REGS_CNT-1:0] busy;
  logic claim_ok;
  assign claim_ok = claim_en && !(ZERO_REG != 0 && claim_addr == '0);
  // claim is applied last so it overrides a same-cycle write-back clear
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else begin
      for (int k = 0; k < WR_PORTS; k++)
        if (wr_en[k]) busy[wr_addr[k]] <= 1'b0;
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (claim_ok) busy[claim_addr] <= 1'b1;
    end
  always_comb begin
    rd_busy = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      rd_busy[j] = busy[rd_addr[j]] && !(ZERO_REG != 0 && rd_addr[j] == '0);
      for (int k = 0; k < WR_PORTS; k++)
        if (byp_en && wr_en[k] && wr_addr[k] == rd_addr[j]) rd_busy[j] = 1'b0;
    end
  end
endmodule

// File: rtl/cpu_regs_mp.sv
// cpu_regs_mp: parametrised multi-port register file with bypass, busy scoreboard and sequential clear
module cpu_regs_mp
  import cpu_regs_mp_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_WIDTH,
  parameter int ADDR_W   = REG_ADDR_WIDTH,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  cpu_regs_mp_if.slave  bus
);
  localparam int REGS_CNT = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  regs_clr_state_t                     state;
  logic [ADDR_W-1:0]                   cnt;
  logic [DATA_W-1:0]                   regs [REGS_CNT];
  logic [WR_PORTS-1:0]                 wr_en;
  logic [WR_PORTS-1:0][ADDR_W-1:0]     wr_addr;
  logic [RD_PORTS-1:0][DATA_W-1:0]     rd_data;
  logic                                clr_busy;
  logic                                byp_en;
  assign clr_busy       = state != RC_IDLE;
  assign byp_en         = BYPASS != 0 && !clr_busy;
  assign bus.clr_busy_o = clr_busy;
  assign bus.rd_data_o  = rd_data;
  // accepted writes: none during a clear, none to a hardwired r0
  for (genvar k = 0; k < WR_PORTS; k++) begin : g_wr
    assign wr_addr[k] = bus.task_i[k].reg_addr;
    assign wr_en[k]   = bus.task_i[k].wr_en && !clr_busy && !(ZERO_REG != 0 && wr_addr[k] == '0);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= RC_IDLE;
      cnt   <= '0;
    end else if (state == RC_IDLE && bus.clr_req_i) begin
      state <= RC_CLEAR;
      cnt   <= '0;
    end else if (state == RC_CLEAR) begin
      state <= cnt == LAST ? RC_DONE : RC_CLEAR;
      cnt   <= cnt == LAST ? cnt : cnt + 1'b1;
    end else if (state == RC_DONE) begin
      state <= RC_IDLE;
      cnt   <= '0;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int i = 0; i < REGS_CNT; i++) regs[i] <= '0;
    else begin
      for (int k = 0; k < WR_PORTS; k++)
        if (wr_en[k]) regs[wr_addr[k]] <= bus.task_i[k].wr_data;
      if (state == RC_CLEAR) regs[cnt] <= '0;
    end
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      rd_data[j] = regs[bus.rd_addr_i[j]];
      for (int k = 0; k < WR_PORTS; k++)
        if (byp_en && wr_en[k] && wr_addr[k] == bus.rd_addr_i[j]) rd_data[j] = bus.task_i[k].wr_data;
      if (ZERO_REG != 0 && bus.rd_addr_i[j] == '0) rd_data[j] = '0;
    end
  end
  cpu_regs_mp_scoreboard #(
    .ADDR_W   (ADDR_W),
    .RD_PORTS (RD_PORTS),
    .WR_PORTS (WR_PORTS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk_i),
    .rst        (rst_i),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (bus.claim_en_i && !clr_busy),
    .claim_addr (bus.claim_addr_i),
    .clr_en     (state == RC_CLEAR),
    .clr_addr   (cnt),
    .byp_en     (byp_en),
    .rd_addr    (bus.rd_addr_i),
    .rd_busy    (bus.rd_busy_o)
  );
endmodule

// File: tb/tb_cpu_regs_mp.sv
// tb_cpu_regs_mp: bypass and non-bypass instances against a reference model, vector table and clear/reset sequences
module tb_cpu_regs_mp;
  import cpu_regs_mp_pkg::*;
  logic clk, rst;
  int checks, errors;
  cpu_regs_mp_if a ();
  cpu_regs_mp_if b ();
  assign b.task_i       = a.task_i;
  assign b.rd_addr_i    = a.rd_addr_i;
  assign b.claim_en_i   = a.claim_en_i;
  assign b.claim_addr_i = a.claim_addr_i;
  assign b.clr_req_i    = a.clr_req_i;
  cpu_regs_mp #(.BYPASS(1)) dut    (.clk_i(clk), .rst_i(rst), .bus(a));
  cpu_regs_mp #(.BYPASS(0)) dut_nb (.clk_i(clk), .rst_i(rst), .bus(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  logic [15:0] mregs [8];
  logic        mbusy [8];
  int          phase;
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
    phase = -1;
  endtask
  function automatic bit wr_hit(logic [2:0] ad);
    for (int k = 0; k < 2; k++)
      if (a.task_i[k].wr_en && a.task_i[k].reg_addr == ad) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [15:0] exp_data(int j, bit byp);
    logic [2:0] ad = a.rd_addr_i[j];
    logic [15:0] v;
    if (ad == 0) return 16'h0;
    v = mregs[ad];
    if (byp && phase < 0)
      for (int k = 0; k < 2; k++)
        if (a.task_i[k].wr_en && a.task_i[k].reg_addr == ad) v = a.task_i[k].wr_data;
    return v;
  endfunction
  function automatic logic exp_busy(int j, bit byp);
    logic [2:0] ad = a.rd_addr_i[j];
    if (ad == 0) return 1'b0;
    if (byp && phase < 0 && wr_hit(ad)) return 1'b0;
    return mbusy[ad];
  endfunction
  task automatic model_update();
    if (phase < 0) begin
      for (int k = 0; k < 2; k++)
        if (a.task_i[k].wr_en && a.task_i[k].reg_addr != 0) begin
          mregs[a.task_i[k].reg_addr] = a.task_i[k].wr_data;
          mbusy[a.task_i[k].reg_addr] = 1'b0;
        end
      if (a.claim_en_i && a.claim_addr_i != 0) mbusy[a.claim_addr_i] = 1'b1;
      if (a.clr_req_i) phase = 0;
    end else begin
      if (phase < 8) begin mregs[phase] = '0; mbusy[phase] = 1'b0; end
      phase++;
      if (phase == 9) phase = -1;
    end
  endtask
  task automatic model_check();
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("m_data_byp[%0d]", j), a.rd_data_o[j], exp_data(j, 1));
      chk($sformatf("m_busy_byp[%0d]", j), a.rd_busy_o[j], exp_busy(j, 1));
      chk($sformatf("m_data_nb[%0d]", j),  b.rd_data_o[j], exp_data(j, 0));
      chk($sformatf("m_busy_nb[%0d]", j),  b.rd_busy_o[j], exp_busy(j, 0));
    end
    chk("m_clr_busy_byp", a.clr_busy_o, phase >= 0);
    chk("m_clr_busy_nb",  b.clr_busy_o, phase >= 0);
  endtask
  task automatic step();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic idle();
    a.task_i     = '0;
    a.claim_en_i = 1'b0;
    a.claim_addr_i = '0;
    a.clr_req_i  = 1'b0;
  endtask
  task automatic wr(int p, logic [2:0] ad, logic [15:0] d);
    a.task_i[p].wr_en = 1'b1; a.task_i[p].reg_addr = ad; a.task_i[p].wr_data = d;
  endtask
  typedef struct {
    logic we0; logic [2:0] a0; logic [15:0] d0;
    logic we1; logic [2:0] a1; logic [15:0] d1;
    logic ce;  logic [2:0] ca;
    logic [2:0] r0, r1;
    logic [15:0] x0, x1; logic xb0, xb1;
    logic [15:0] y0, y1; logic yb0, yb1;
  } vec_t;
  vec_t tbl [13];
  int hi;
  initial begin
    checks = 0; errors = 0;
    tbl[0]  = '{1, 3, 16'h1234, 0, 0, 16'h0,    0, 0, 0, 3, 16'h0,    16'h1234, 0, 0, 16'h0,    16'h0,    0, 0};
    tbl[1]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3, 3, 16'h1234, 16'h1234, 0, 0, 16'h1234, 16'h1234, 0, 0};
    tbl[2]  = '{1, 5, 16'hAAAA, 1, 5, 16'h5555, 0, 0, 5, 5, 16'h5555, 16'h5555, 0, 0, 16'h0,    16'h0,    0, 0};
    tbl[3]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 5, 0, 16'h5555, 16'h0,    0, 0, 16'h5555, 16'h0,    0, 0};
    tbl[4]  = '{1, 0, 16'hFFFF, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0,    16'h0,    0, 0};
    tbl[5]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0,    16'h0,    0, 0};
    tbl[6]  = '{0, 0, 16'h0,    0, 0, 16'h0,    1, 2, 2, 2, 16'h0,    16'h0,    0, 0, 16'h0,    16'h0,    0, 0};
    tbl[7]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 2, 2, 16'h0,    16'h0,    1, 1, 16'h0,    16'h0,    1, 1};
    tbl[8]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 2, 2, 16'h0,    16'h0,    1, 1, 16'h0,    16'h0,    1, 1};
    tbl[9]  = '{0, 0, 16'h0,    1, 2, 16'h0042, 0, 0, 2, 2, 16'h0042, 16'h0042, 0, 0, 16'h0,    16'h0,    1, 1};
    tbl[10] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 2, 2, 16'h0042, 16'h0042, 0, 0, 16'h0042, 16'h0042, 0, 0};
    tbl[11] = '{1, 2, 16'h0077, 0, 0, 16'h0,    1, 2, 2, 2, 16'h0077, 16'h0077, 0, 0, 16'h0042, 16'h0042, 0, 0};
    tbl[12] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 2, 5, 16'h0077, 16'h5555, 1, 0, 16'h0077, 16'h5555, 1, 0};
    rst = 1'b1;
    idle();
    a.rd_addr_i = '0;
    a.rd_addr_i[1] = 3'd3;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_clr_busy", a.clr_busy_o, 0);
    chk("reset_r3_data", a.rd_data_o[1], 0);
    chk("reset_r3_busy", a.rd_busy_o[1], 0);
    rst = 1'b0;
    @(posedge clk); model_update(); @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      idle();
      a.task_i[0] = '{tbl[i].we0, tbl[i].a0, tbl[i].d0};
      a.task_i[1] = '{tbl[i].we1, tbl[i].a1, tbl[i].d1};
      a.claim_en_i = tbl[i].ce; a.claim_addr_i = tbl[i].ca;
      a.rd_addr_i[0] = tbl[i].r0; a.rd_addr_i[1] = tbl[i].r1;
      #1;
      chk($sformatf("vec%0d_d0", i),     a.rd_data_o[0], tbl[i].x0);
      chk($sformatf("vec%0d_d1", i),     a.rd_data_o[1], tbl[i].x1);
      chk($sformatf("vec%0d_b0", i),     a.rd_busy_o[0], tbl[i].xb0);
      chk($sformatf("vec%0d_b1", i),     a.rd_busy_o[1], tbl[i].xb1);
      chk($sformatf("vec%0d_nb_d0", i),  b.rd_data_o[0], tbl[i].y0);
      chk($sformatf("vec%0d_nb_d1", i),  b.rd_data_o[1], tbl[i].y1);
      chk($sformatf("vec%0d_nb_b0", i),  b.rd_busy_o[0], tbl[i].yb0);
      chk($sformatf("vec%0d_nb_b1", i),  b.rd_busy_o[1], tbl[i].yb1);
      step();
    end
    for (int i = 1; i < 8; i++) begin idle(); wr(0, 3'(i), 16'(16'h0011 * i)); step(); end
    idle(); a.claim_en_i = 1'b1; a.claim_addr_i = 3'd6; step();
    idle(); a.clr_req_i = 1'b1; a.rd_addr_i[0] = 3'd4; a.rd_addr_i[1] = 3'd6; step();
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (c == 3) begin wr(1, 3'd4, 16'hBEEF); a.claim_en_i = 1'b1; a.claim_addr_i = 3'd4; end
      if (a.clr_busy_o) hi++;
      step();
    end
    chk("clr_busy_len", hi, 9);
    for (int i = 0; i < 8; i++) begin
      idle(); a.rd_addr_i[0] = 3'(i); a.rd_addr_i[1] = 3'(7 - i);
      #1;
      chk($sformatf("cleared_r%0d", i), a.rd_data_o[0], 0);
      chk($sformatf("cleared_busy_r%0d", i), a.rd_busy_o[0], 0);
      step();
    end
    idle(); wr(0, 3'd5, 16'h0055); step();
    idle(); wr(0, 3'd6, 16'h0066); wr(1, 3'd7, 16'h0077); step();
    idle(); a.clr_req_i = 1'b1; step();
    idle(); a.rd_addr_i[0] = 3'd6; a.rd_addr_i[1] = 3'd7;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("midclr_rst_clr_busy", a.clr_busy_o, 0);
    chk("midclr_rst_r6", a.rd_data_o[0], 0);
    chk("midclr_rst_r7", a.rd_data_o[1], 0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk); model_update(); @(negedge clk);
    idle(); wr(0, 3'd1, 16'h0101); wr(1, 3'd2, 16'h0202); step();
    idle(); a.clr_req_i = 1'b1; a.rd_addr_i[0] = 3'd1; a.rd_addr_i[1] = 3'd2; step();
    idle(); step();
    #1 chk("restart_r1_kept", a.rd_data_o[0], 16'h0101);
    step();
    #1 chk("restart_r1_wiped", a.rd_data_o[0], 0);
    chk("restart_r2_kept", a.rd_data_o[1], 16'h0202);
    repeat (10) step();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1) == 1) wr(k, 3'($urandom_range(0, 7)), 16'($urandom));
      a.claim_en_i   = $urandom_range(0, 9) < 3;
      a.claim_addr_i = 3'($urandom_range(0, 7));
      a.clr_req_i    = $urandom_range(0, 39) == 0;
      a.rd_addr_i[0] = 3'($urandom_range(0, 7));
      a.rd_addr_i[1] = 3'($urandom_range(0, 7));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_regs_mp.md
Name: cpu_regs_mp

Overview:
Parametrised multi-port register file for the risc16 core, replacing the fixed 2-read/1-write file.
- Configurable number of read and write-back ports.
- Optional hardwired-zero r0.
- Optional write-to-read bypass.
- Per-register busy scoreboard for hazard detection.
- Sequential clear engine that wipes the file one register per cycle.

Sits between the decode stage (read ports, claims) and the write-back stages (task_i ports).

Parameters:
- DATA_W, default REG_DATA_WIDTH (16): register width.
- ADDR_W, default REG_ADDR_WIDTH (3): register address width. REGS_CNT = 2**ADDR_W.
- RD_PORTS, default 2: number of read ports, 1..4.
- WR_PORTS, default 2: number of write-back ports, 1..3.
- ZERO_REG, default 1: 1 = r0 reads 0, ignores writes and is never busy.
- BYPASS, default 1: 1 = same-cycle write data is forwarded to matching reads.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- task_i, input, wb_task_t x WR_PORTS: write-back requests {wr_en, reg_addr, wr_data}.
- rd_addr_i, input, ADDR_W x RD_PORTS: read addresses.
- rd_data_o, output, DATA_W x RD_PORTS: read data, combinational.
- rd_busy_o, output, RD_PORTS: addressed register has a pending producer.
- claim_en_i, input, 1: decode issues an instruction that will write claim_addr_i.
- claim_addr_i, input, ADDR_W: destination register being claimed.
- clr_req_i, input, 1: start sequential clear (pulse or level).
- clr_busy_o, output, 1: clear engine active; decode must stall.

Behaviour:
- Reset (async, active-high): all regs 0, all busy bits 0, FSM IDLE, clear counter 0. clr_busy_o = 0.
- Writes:
  - Register updates on the clock edge after task_i[k].wr_en.
  - If several ports target the same address in one cycle, the highest port index wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads:
  - Combinational, zero latency.
  - ZERO_REG=1 and address 0: data 0, busy 0.
  - BYPASS=1: if any enabled write this cycle targets rd_addr_i[j] (excluding r0 when ZERO_REG=1), rd_data_o[j] = that wr_data, highest port index winning. Otherwise the stored value.
  - BYPASS=0: always the stored value; a write is visible the cycle after.
- Scoreboard, busy[REGS_CNT], updated at the clock edge:
  - A write to addr clears busy[addr].
  - claim_en_i sets busy[claim_addr_i].
  - Claim and write to the same addr in the same cycle: claim wins, bit stays 1.
  - Claims of r0 are ignored when ZERO_REG=1.
  - rd_busy_o[j] = busy[rd_addr_i[j]]. When BYPASS=1, it is forced to 0 if a write targets that addr this cycle.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clr_req_i: counter <= 0, clr_busy_o <= 1 (registered; high the cycle after the request).
  - CLEAR: each cycle regs[counter] <= 0, busy[counter] <= 0, counter++. At counter == REGS_CNT-1 -> DONE.
  - DONE: one cycle, clr_busy_o still 1 -> IDLE, clr_busy_o <= 0.
  - Total clr_busy_o high time: REGS_CNT+1 cycles.
  - While clr_busy_o=1: task_i writes and claims are ignored, and reads return stored values with no bypass.
  - clr_req_i while not IDLE is ignored. Counter wraps only via the DONE->IDLE path.
- Reset asserted mid-clear: immediate return to IDLE, everything 0.

Decomposition:
- risc16 package holds:
  - REG_ADDR_WIDTH and REG_DATA_WIDTH.
  - wb_task_t (unchanged).
  - New enum regs_clr_state_t {RC_IDLE, RC_CLEAR, RC_DONE}.
- One natural sub-module, cpu_regs_scoreboard: busy bit array, claim/clear priority, and per-port busy lookup with the bypass mask.
- Storage, write priority, bypass mux and clear FSM stay in cpu_regs_mp.

Test Plan:
1. Reset, then write r3=0x1234 on port 0 and read r3 on port 1 in the same cycle, BYPASS=1 -> rd_data_o[1]=0x1234 that cycle. With BYPASS=0 -> 0x0000 that cycle, 0x1234 the next.
2. Same cycle: port0 writes r5=0xAAAA and port1 writes r5=0x5555 -> r5 reads 0x5555 afterwards.
3. ZERO_REG=1: write r0=0xFFFF and claim r0 -> r0 reads 0x0000 and rd_busy_o=0 on all ports.
4. Claim r2, then 2 idle cycles -> rd_busy_o=1 for r2. Write r2=0x0042 -> busy=0 that cycle (bypass) and the data is bypassed. Claim and write r2 in the same cycle -> busy stays 1.
5. Fill r1..r7 with 0x0011*i, pulse clr_req_i -> clr_busy_o high exactly 9 cycles (ADDR_W=3); a write to r4 during the clear is dropped; all registers read 0 afterwards and all busy bits are 0.
6. Assert rst_i asynchronously mid-clear with counter=4 -> clr_busy_o=0 immediately, all registers 0. After release a new clr_req_i starts from counter 0.
